// File: rtl/wbu.sv
// wbu: write-back stage that sits directly after the load/store stage.
// It takes one retiring instruction per s_valid/s_ready handshake and picks
// the write-back value from ALU, load data, pc+4 or CSR. It owns the
// architectural register file and presents the next pc to fetch through
// m_valid/m_ready. Each accepted instruction passes through IDLE -> WRITE ->
// WAIT_READY, so instructions never overlap.
// rst is active-low and asserts asynchronously. Its release is expected to be
// synchronised to clk by the reset network upstream.
module wbu #(
  parameter int DATA_LEN = 32,
  parameter int NR_REG   = 32,
  parameter int REG_AW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic [REG_AW-1:0]   rdX,
  input  logic                rwenX,
  input  logic [1:0]          wbselX,
  input  logic [DATA_LEN-1:0] ALU_resultX,
  input  logic [DATA_LEN-1:0] mdataM,
  input  logic [DATA_LEN-1:0] pcX,
  input  logic [DATA_LEN-1:0] dnpcX,
  input  logic [DATA_LEN-1:0] csr_rdataX,
  input  logic [REG_AW-1:0]   raddr1,
  input  logic [REG_AW-1:0]   raddr2,
  output logic [DATA_LEN-1:0] rdata1,
  output logic [DATA_LEN-1:0] rdata2,
  output logic [DATA_LEN-1:0] dnpc,
  output logic [63:0]         instret
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    WAIT_READY = 2'd2
  } state_t;

  state_t              state;
  logic                s_ready_q;
  logic                m_valid_q;
  logic [REG_AW-1:0]   rd_q;
  logic                rwen_q;
  logic [DATA_LEN-1:0] wb_q;
  logic [DATA_LEN-1:0] dnpc_q;
  logic [63:0]         instret_q;
  logic [DATA_LEN-1:0] wb_value;
  logic [DATA_LEN-1:0] regs [NR_REG];

  // Select the write-back value from the inputs the load/store stage holds stable.
  always_comb begin
    wb_value = ALU_resultX;
    case (wbselX)
      2'd0: wb_value = ALU_resultX;
      2'd1: wb_value = mdataM;
      2'd2: wb_value = pcX + DATA_LEN'(4);
      2'd3: wb_value = csr_rdataX;
      default: wb_value = ALU_resultX;
    endcase
  end

  // Handshake FSM: latch on accept, write in WRITE, then hold retirement until fetch takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      rd_q      <= '0;
      rwen_q    <= 1'b0;
      wb_q      <= '0;
      dnpc_q    <= '0;
      instret_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            rd_q      <= rdX;
            rwen_q    <= rwenX;
            wb_q      <= wb_value;
            dnpc_q    <= dnpcX;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b1;
          state     <= WAIT_READY;
        end
        WAIT_READY: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            instret_q <= instret_q + 64'd1;
            state     <= IDLE;
          end
        end
        default: begin
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Register file write port; x0 is never written and reset clears every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_REG; i++) begin
        regs[i] <= '0;
      end
    end else if (state == WRITE && rwen_q && rd_q != '0) begin
      regs[rd_q] <= wb_q;
    end
  end

  // Decode reads straight from the array. There is no bypass, and x0 always reads 0.
  assign rdata1  = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2  = (raddr2 == '0) ? '0 : regs[raddr2];
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign dnpc    = dnpc_q;
  assign instret = instret_q;

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
- Write-back stage directly downstream of the load/store stage.
- Accepts one retiring instruction per handshake from the load/store stage and selects the write-back value: ALU result, loaded data, pc+4 or CSR read data.
- Owns the architectural register file: two combinational read ports for decode and one write port used here.
- Signals retirement and next pc to the fetch stage through a valid/ready handshake, and counts retired instructions.

Parameters:
- DATA_LEN, 32, register and datapath width.
- NR_REG, 32, number of architectural registers; x0 is hardwired to zero.
- REG_AW, 5, register index width (log2 NR_REG).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low, synchronous release.
- s_valid  in  1  upstream instruction valid; driven from the load/store stage's m_valid.
- s_ready  out  1  WBU can accept; drives the load/store stage's m_ready.
- m_valid  out  1  instruction retired; next pc valid to fetch.
- m_ready  in  1  fetch accepts retirement.
- rdX  in  REG_AW  destination register index.
- rwenX  in  1  register write enable.
- wbselX  in  2  write-back select: 0 ALU, 1 mem, 2 pc+4, 3 CSR.
- ALU_resultX  in  DATA_LEN  ALU result.
- mdataM  in  DATA_LEN  extended load data from the load/store stage; stable while s_valid.
- pcX  in  DATA_LEN  pc of the instruction.
- dnpcX  in  DATA_LEN  computed next pc.
- csr_rdataX  in  DATA_LEN  CSR old value.
- raddr1, raddr2  in  REG_AW  read indices.
- rdata1, rdata2  out  DATA_LEN  combinational read data; 0 when index is 0.
- dnpc  out  DATA_LEN  latched next pc, valid while m_valid.
- instret  out  64  retired-instruction counter.

Behaviour:
- All X-suffixed inputs and mdataM are held stable by upstream while s_valid=1. WBU samples them only on the accept edge (s_valid & s_ready).
- FSM states: IDLE, WRITE, WAIT_READY. Illegal encodings go to IDLE.
  - IDLE: s_ready=1. On s_valid, latch rd, rwen, dnpc and the selected wb value, then go to WRITE.
  - WRITE: s_ready=0, m_valid=0. If latched rwen=1 and rd!=0, write the wb value to regs[rd] at the end of this cycle. Always go to WAIT_READY.
  - WAIT_READY: m_valid=1. If m_ready, go to IDLE and increment instret; otherwise hold. m_valid does not drop, and dnpc stays stable, until accepted.
- Latency: accept at edge N, register write at edge N+1, m_valid high from cycle N+2. Minimum 3 cycles per instruction; no overlap.
- Write-back value:
  - wbsel 0: ALU_resultX.
  - wbsel 1: mdataM.
  - wbsel 2: pcX+4, mod 2^32, so 0xFFFFFFFC gives 0.
  - wbsel 3: csr_rdataX.
- Read ports: purely combinational from the array. A write in WRITE becomes visible on rdata the cycle after its edge; no bypass.
- x0: writes are discarded; reads of index 0 always return 0.
- rwen=0: no array change, but the instruction still retires, with m_valid and instret behaving normally.
- instret: 64-bit, wraps from all-ones to 0.
- Reset (rst low, any state, including WRITE): state goes to IDLE immediately and asynchronously.
  - Outputs: s_ready=1, m_valid=0, dnpc=0, instret=0.
  - All registers 0, latched fields 0.
  - An in-flight write is abandoned: a write in WRITE does not occur if rst is low at that edge.
- s_valid asserted while not in IDLE is ignored (s_ready=0); upstream holds it.

Test Plan:
- Reset release then ALU write: rdX=5, rwen=1, wbsel=0, ALU_resultX=0x12345678, dnpcX=0x80000004, m_ready=1 -> m_valid high exactly 2 cycles after accept with dnpc=0x80000004; rdata1 with raddr1=5 reads 0x12345678 from the cycle after WRITE; instret=1.
- Load and link: wbsel=1 with mdataM=0xFFFFFF80 into x7 -> x7=0xFFFFFF80; wbsel=2 with pcX=0xFFFFFFFC into x1 -> x1=0; wbsel=3 with csr_rdataX=0xA5A5A5A5 into x2 -> x2=0xA5A5A5A5.
- x0 and rwen=0: write 0xDEADBEEF to rd=0, then rd=3 with rwen=0 -> both reads return 0; instret increments by 2.
- Backpressure: hold m_ready=0 for 5 cycles in WAIT_READY with s_valid=1 -> m_valid and dnpc stable, s_ready=0, instret unchanged; raise m_ready -> one retirement, IDLE next cycle, next instruction accepted.
- Async reset in WRITE: assert rst low mid-cycle while in WRITE with rd=4 -> s_ready=1 and m_valid=0 immediately, x4 stays 0, instret=0.
- instret wrap: force instret to all-ones and retire one instruction -> instret=0.
